binwin_stream6x6: RTL
=====================

Name: binwin_stream6x6

Overview:
Upstream feeder for the binary conv+pool pixel stage. It accepts a raster-order 1-bit binarized image stream and buffers six rows. It emits every 6x6 window at stride 2 in both directions, which equals the 2x2 pool stride of the consumer. Each window goes out as a 36-entry 1-bit array, index row*6+col, and is held stable under a valid/ready handshake while the consumer's combinational conv+pool evaluates it.

Parameters:
IMG_W, 28, image width in pixels; even, >= 6
IMG_H, 28, image height in pixels; even, >= 6
CW, $clog2(IMG_W), width of column index outputs
RW, $clog2(IMG_H), width of row index outputs

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  in_bit is valid this cycle
in_ready  out  1  block accepts in_bit this cycle
in_bit  in  1  next pixel, raster order: row 0 col 0 first
out_valid  out  1  window is valid
out_ready  in  1  consumer takes window this cycle
window  out  1 x 36 (unpacked [0:35])  window[i*6+j] = pixel(out_row+i, out_col+j)
out_row  out  RW  top row of current window
out_col  out  CW  left column of current window
out_last  out  1  current window is the final one of the frame; qualified by out_valid

Behaviour:
- Storage: 6 row slots of IMG_W bits. Circular slot pointer wr_slot; base_slot marks the slot that holds row out_row.
- Pixel accept when in_valid & in_ready; write goes to slot wr_slot, column in_col.
  - in_col increments per accept.
  - At IMG_W-1: in_col -> 0, wr_slot -> (wr_slot+1) mod 6, rows_pending decrements.
- FSM states FILL, EMIT. Reset state: FILL, rows_pending = 6, all counters and pointers 0.
- FILL:
  - in_ready = 1 (0 while rst asserted); out_valid = 0.
  - Completing the last pixel of the pending rows (rows_pending reaches 0) -> EMIT next cycle.
  - First out_valid therefore comes 1 cycle after the accept of pixel (5, IMG_W-1).
- EMIT:
  - in_ready = 0; out_valid = 1.
  - window is muxed from slots (base_slot+i) mod 6, columns out_col..out_col+5.
  - window, out_row, out_col and out_last are stable while out_valid & !out_ready.
  - On handshake, if out_col < IMG_W-6: out_col += 2, stay in EMIT.
  - Else if out_row < IMG_H-6: out_col = 0, out_row += 2, base_slot = (base_slot+2) mod 6, rows_pending = 2 -> FILL. The two incoming rows overwrite the two oldest slots.
  - Else (final window): clear all counters/pointers, rows_pending = 6 -> FILL. The next frame is accepted starting the following cycle.
- out_last = (out_row == IMG_H-6) & (out_col == IMG_W-6).
- Window count per frame: ((IMG_W-6)/2+1) * ((IMG_H-6)/2+1); 144 at defaults.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready depends on state only.
- Reset asserted at any time (mid-FILL or mid-EMIT) takes effect immediately:
  - out_valid = 0, in_ready = 0, state FILL, all counters cleared.
  - Partial frame discarded; buffer contents need no clearing.
- in_bit is ignored when in_valid is 0 or in_ready is 0.
- Elaboration: assertion on IMG_W/IMG_H odd or < 6.

Decomposition:
- Package binwin_pkg:
  - WIN = 6, WIN_AREA = 36, STRIDE = 2
  - typedef enum logic {FILL, EMIT} binwin_state_t
  - function slot_add(a, b) returning (a+b) mod 6
- Sub-module binwin_rowbuf:
  - 6 x IMG_W bit storage, single write port (slot, col, bit).
  - Combinational 6x6 read at (base_slot, col).
- FSM and counters live in the top module.

Test Plan:
1. IMG_W=IMG_H=8, pixel(r,c) = r[0]^c[0], out_ready=1 -> out_valid rises 1 cycle after the 48th accept. Exactly 4 windows at (row,col) = (0,0),(0,2),(2,0),(2,2), each with window[i*6+j] = i[0]^j[0]. out_last only on (2,2). in_ready=0 between 1st window and resumption; 16 more accepts precede window 3.
2. Backpressure: hold out_ready=0 for 5 cycles on window (0,2) -> window, out_row=0, out_col=2 stable. out_valid stays 1, in_ready stays 0, no window skipped.
3. Random in_valid gaps (about 50% duty) on the case 1 image -> identical window sequence and contents.
4. Two back-to-back frames, the second one inverted -> in_ready=1 the cycle after the out_last handshake. Second frame's windows are the bitwise inverse of the first; no data carries over.
5. Reset pulse during EMIT at window (2,0) -> out_valid=0 and in_ready=0 immediately. After release, a fresh frame yields the full 4-window sequence starting at (0,0).
6. Defaults 28x28, single 1 at pixel (27,27) -> 144 windows. Only the last (out_row=22, out_col=22, out_last=1) has window[35]=1; all other window bits are 0.

Source files
------------

// File: rtl/binwin_pkg.sv
// Shared types and helpers for the 6x6 stride-2 binary window streamer.
package binwin_pkg;

    localparam int unsigned WIN      = 6;
    localparam int unsigned WIN_AREA = 36;
    localparam int unsigned STRIDE   = 2;
    localparam int unsigned SLOT_W   = 3;
    localparam int unsigned SUM_W    = SLOT_W + 1;

    typedef enum logic {FILL, EMIT} binwin_state_t;

    typedef logic [SLOT_W-1:0] slot_t;

    // Circular row-slot arithmetic over the six buffered rows.
    function automatic slot_t slot_add(input slot_t a, input slot_t b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= SUM_W'(WIN)) begin
            sum = sum - SUM_W'(WIN);
        end
        return sum[SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/binwin_rowbuf.sv
// Six-row bit buffer: one write port, combinational 6x6 window read.
module binwin_rowbuf
    import binwin_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  slot_t         wr_slot,
    input  logic [CW-1:0] wr_col,
    input  logic          wr_bit,
    input  slot_t         rd_slot,
    input  logic [CW-1:0] rd_col,
    output logic          rd_win [0:WIN_AREA-1]
);

    logic [IMG_W-1:0] mem [0:WIN-1];

    // Contents are never cleared; a frame always overwrites before reading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_bit;
        end
    end

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                rd_win[i*WIN+j] = mem[slot_add(rd_slot, SLOT_W'(i))][rd_col + CW'(j)];
            end
        end
    end

endmodule

// File: rtl/binwin_stream6x6.sv
// Raster bit stream in, every 6x6 window at stride 2 out under valid/ready.
module binwin_stream6x6
    import binwin_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned CW    = $clog2(IMG_W),
    parameter int unsigned RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          window [0:WIN_AREA-1],
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last
);

    if ((IMG_W % 2) != 0 || IMG_W < WIN || (IMG_H % 2) != 0 || IMG_H < WIN) begin : g_dim_check
        $fatal(1, "binwin_stream6x6: IMG_W and IMG_H must be even and >= 6");
    end

    localparam logic [CW-1:0] COL_END      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_LAST_WIN = CW'(IMG_W - WIN);
    localparam logic [RW-1:0] ROW_LAST_WIN = RW'(IMG_H - WIN);

    binwin_state_t     state_q, state_d;
    logic [CW-1:0]     in_col_q, in_col_d;
    slot_t             wr_slot_q, wr_slot_d;
    slot_t             base_slot_q, base_slot_d;
    logic [SLOT_W-1:0] rows_pending_q, rows_pending_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic [CW-1:0]     out_col_q, out_col_d;
    logic              accept;

    assign in_ready  = (state_q == FILL) & ~rst;
    assign out_valid = (state_q == EMIT);
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = (out_row_q == ROW_LAST_WIN) & (out_col_q == COL_LAST_WIN);
    assign accept    = in_valid & in_ready;

    binwin_rowbuf #(
        .IMG_W (IMG_W),
        .CW    (CW)
    ) u_rowbuf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_slot (wr_slot_q),
        .wr_col  (in_col_q),
        .wr_bit  (in_bit),
        .rd_slot (base_slot_q),
        .rd_col  (out_col_q),
        .rd_win  (window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            in_col_q       <= '0;
            wr_slot_q      <= '0;
            base_slot_q    <= '0;
            rows_pending_q <= SLOT_W'(WIN);
            out_row_q      <= '0;
            out_col_q      <= '0;
        end else begin
            state_q        <= state_d;
            in_col_q       <= in_col_d;
            wr_slot_q      <= wr_slot_d;
            base_slot_q    <= base_slot_d;
            rows_pending_q <= rows_pending_d;
            out_row_q      <= out_row_d;
            out_col_q      <= out_col_d;
        end
    end

    // FILL collects the pending rows; EMIT walks windows until more rows are needed.
    always_comb begin
        state_d        = state_q;
        in_col_d       = in_col_q;
        wr_slot_d      = wr_slot_q;
        base_slot_d    = base_slot_q;
        rows_pending_d = rows_pending_q;
        out_row_d      = out_row_q;
        out_col_d      = out_col_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_col_q == COL_END) begin
                        in_col_d       = '0;
                        wr_slot_d      = slot_add(wr_slot_q, SLOT_W'(1));
                        rows_pending_d = rows_pending_q - SLOT_W'(1);
                        if (rows_pending_q == SLOT_W'(1)) begin
                            state_d = EMIT;
                        end
                    end else begin
                        in_col_d = in_col_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_col_q < COL_LAST_WIN) begin
                        out_col_d = out_col_q + CW'(STRIDE);
                    end else if (out_row_q < ROW_LAST_WIN) begin
                        // Two new rows replace the two oldest slots.
                        out_col_d      = '0;
                        out_row_d      = out_row_q + RW'(STRIDE);
                        base_slot_d    = slot_add(base_slot_q, SLOT_W'(STRIDE));
                        rows_pending_d = SLOT_W'(STRIDE);
                        state_d        = FILL;
                    end else begin
                        in_col_d       = '0;
                        wr_slot_d      = '0;
                        base_slot_d    = '0;
                        out_row_d      = '0;
                        out_col_d      = '0;
                        rows_pending_d = SLOT_W'(WIN);
                        state_d        = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

endmodule
